led_game_controller: RTL
========================

Name: led_game_controller

Overview:
- Sequencing FSM for the 8-LED catch game on the labkit: owns player position, target spawn, round timing, score and miss count.
- Replaces the free-running movement/target/score glue with one controlled round flow: IDLE -> SPAWN -> PLAY -> HIT/MISS -> SPAWN ... -> WIN/LOSE.
- Outputs drive the LED bank (player_led | target_led) and the seven-segment score digit.

Parameters:
- TICK_DIV, 100000000, clk cycles per game tick (use 4 in simulation).
- ROUND_TICKS, 5, ticks allowed per round, range 1..15.
- WIN_SCORE, 9, score that ends the game in WIN, range 1..9.
- MAX_MISSES, 3, misses that end the game in LOSE, range 1..3.
- LFSR_SEED, 8'hA5, LFSR reset value, must be nonzero.

Ports:
- clk_100mhz  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_enter  in  1  start/restart button, debounced level, active high.
- btn_left  in  1  move player toward bit 7, debounced level.
- btn_right  in  1  move player toward bit 0, debounced level.
- player_led  out  8  one-hot player position.
- target_led  out  8  one-hot target, or 0 when no target.
- score  out  4  binary hits this game, 0..WIN_SCORE.
- misses  out  2  misses this game, 0..MAX_MISSES.
- round_time  out  4  ticks remaining in the current round.
- state  out  3  IDLE=0, SPAWN=1, PLAY=2, HIT=3, MISS=4, WIN=5, LOSE=6.
- hit_pulse  out  1  high for exactly the HIT cycle.
- game_over  out  1  high in WIN or LOSE.

Behaviour:
- Reset (sampled high at an edge, including mid-game) sets these values next cycle:
  - state=IDLE, player_led=8'h01, target_led=0, score=0, misses=0, round_time=0.
  - hit_pulse=0, LFSR=LFSR_SEED, tick counter=0, button history=0.
- Button edges: each button has a history flop. rise = btn & ~btn_q, evaluated combinationally and acted on at the same edge. A held button produces exactly one event.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every cycle out of reset, in all states.
- IDLE:
  - player_led and target_led are held.
  - enter rise -> SPAWN, with score=0 and misses=0.
- SPAWN (1 cycle):
  - idx = LFSR[2:0]; if idx equals the player index, idx = (idx+4) mod 8.
  - target_led = 1<<idx, round_time = ROUND_TICKS, tick counter = 0.
  - Then -> PLAY.
- PLAY:
  - left rise shifts player toward bit 7, saturating at 8'h80. Right rise shifts toward bit 0, saturating at 8'h01. Simultaneous left and right rises: no move.
  - Tick counter counts 0..TICK_DIV-1 and wraps; a tick occurs at TICK_DIV-1. On a tick, round_time decrements.
  - Hit condition: registered player_led == target_led, checked every PLAY cycle -> HIT. A hit is therefore seen one cycle after the move that lands on the target.
  - Tick with round_time==1 and no hit -> MISS, with round_time=0.
  - Hit and expiry on the same cycle: HIT wins.
  - enter is ignored in PLAY.
- HIT (1 cycle):
  - hit_pulse=1, score+1, target_led=0.
  - If the new score == WIN_SCORE -> WIN, else -> SPAWN.
- MISS (1 cycle):
  - misses+1, target_led=0.
  - If the new misses == MAX_MISSES -> LOSE, else -> SPAWN.
- WIN/LOSE:
  - game_over=1. target_led=0. score, misses and player_led are frozen. Left/right are ignored.
  - enter rise -> SPAWN with score=0 and misses=0. The player position is kept.
- Score never exceeds WIN_SCORE and misses never exceed MAX_MISSES; neither wraps.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan (TICK_DIV=4, ROUND_TICKS=3, WIN_SCORE=9, MAX_MISSES=3 unless stated):
- Reset, then hold enter low for 20 cycles -> state=0, player_led=8'h01, target_led=0, score=0, game_over=0. Pulse enter -> state=1 for 1 cycle, then 2, with target_led one-hot and != 8'h01.
- Target at bit 2, player at bit 0; two separated left rises -> player 8'h02, then 8'h04. Next cycle HIT with hit_pulse=1 for 1 cycle, score=1, target_led=0; then SPAWN.
- Idle in PLAY with no input -> round_time goes 3,2,1 at 4-cycle intervals, then MISS with misses=1. The third miss -> state=6 (LOSE) and game_over=1.
- Right rise at player 8'h01 and left rise at 8'h80 -> no change. Holding left high 10 cycles -> exactly one move.
- Nine consecutive hits -> score=9, state=5 (WIN). Further left/right rises do not change player_led or score. Enter rise -> score=0, state=1.
- Assert reset mid-PLAY with score=4, misses=2 -> next cycle all outputs equal their reset values, and the LFSR restarts from 8'hA5. Two resets followed by the same stimulus -> identical target sequences.

Source files
------------

// File: rtl/led_game_controller.sv
// Round sequencer for the 8-LED catch game: player movement,
// target spawn, round timer, score and miss tracking.
module led_game_controller #(
    parameter int unsigned TICK_DIV    = 100000000,
    parameter int unsigned ROUND_TICKS = 5,
    parameter int unsigned WIN_SCORE   = 9,
    parameter int unsigned MAX_MISSES  = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk_100mhz,
    input  logic       reset,
    input  logic       btn_enter,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [7:0] player_led,
    output logic [7:0] target_led,
    output logic [3:0] score,
    output logic [1:0] misses,
    output logic [3:0] round_time,
    output logic [2:0] state,
    output logic       hit_pulse,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_PLAY  = 3'd2,
        S_HIT   = 3'd3,
        S_MISS  = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [3:0] RT_INIT = 4'(ROUND_TICKS);
    localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);
    localparam logic [1:0] MISS_MAX = 2'(MAX_MISSES);

    state_t        st;
    logic [7:0]    lfsr;
    logic [CW-1:0] tick_cnt;
    logic          enter_q;
    logic          left_q;
    logic          right_q;

    logic          enter_rise;
    logic          left_rise;
    logic          right_rise;
    logic          tick;
    logic [2:0]    player_idx;
    logic [2:0]    spawn_idx;
    logic          lfsr_fb;

    assign state = st;

    // Edge detect, tick strobe, LFSR feedback and spawn slot selection
    always_comb begin
        enter_rise = btn_enter & ~enter_q;
        left_rise  = btn_left & ~left_q;
        right_rise = btn_right & ~right_q;
        tick       = (tick_cnt == TICK_LAST);
        lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        player_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (player_led[i]) begin
                player_idx = 3'(i);
            end
        end
        // Never spawn on top of the player: push it to the far side
        if (lfsr[2:0] == player_idx) begin
            spawn_idx = lfsr[2:0] + 3'd4;
        end else begin
            spawn_idx = lfsr[2:0];
        end
    end

    // Button history and free-running LFSR
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            enter_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            lfsr    <= LFSR_SEED;
        end else begin
            enter_q <= btn_enter;
            left_q  <= btn_left;
            right_q <= btn_right;
            lfsr    <= {lfsr[6:0], lfsr_fb};
        end
    end

    // Round flow FSM with all game outputs registered
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            st         <= S_IDLE;
            player_led <= 8'h01;
            target_led <= 8'h00;
            score      <= 4'd0;
            misses     <= 2'd0;
            round_time <= 4'd0;
            hit_pulse  <= 1'b0;
            game_over  <= 1'b0;
            tick_cnt   <= '0;
        end else begin
            hit_pulse <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (enter_rise) begin
                        st     <= S_SPAWN;
                        score  <= 4'd0;
                        misses <= 2'd0;
                    end
                end
                S_SPAWN: begin
                    target_led <= 8'h01 << spawn_idx;
                    round_time <= RT_INIT;
                    tick_cnt   <= '0;
                    st         <= S_PLAY;
                end
                S_PLAY: begin
                    if (left_rise && !right_rise && player_led != 8'h80) begin
                        player_led <= player_led << 1;
                    end else if (right_rise && !left_rise
                                 && player_led != 8'h01) begin
                        player_led <= player_led >> 1;
                    end
                    tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
                    if (tick) begin
                        round_time <= round_time - 4'd1;
                    end
                    // A hit takes priority over an expiring round
                    if (player_led == target_led) begin
                        st         <= S_HIT;
                        hit_pulse  <= 1'b1;
                        score      <= score + 4'd1;
                        target_led <= 8'h00;
                    end else if (tick && round_time == 4'd1) begin
                        st         <= S_MISS;
                        misses     <= misses + 2'd1;
                        target_led <= 8'h00;
                    end
                end
                S_HIT: begin
                    if (score == WIN_VAL) begin
                        st        <= S_WIN;
                        game_over <= 1'b1;
                    end else begin
                        st <= S_SPAWN;
                    end
                end
                S_MISS: begin
                    if (misses == MISS_MAX) begin
                        st        <= S_LOSE;
                        game_over <= 1'b1;
                    end else begin
                        st <= S_SPAWN;
                    end
                end
                S_WIN, S_LOSE: begin
                    target_led <= 8'h00;
                    if (enter_rise) begin
                        st        <= S_SPAWN;
                        score     <= 4'd0;
                        misses    <= 2'd0;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule
